// File: rtl/operand_entry_pkg.sv
// Shared types and constants for the operand-capture stage feeding the adder.
package operand_entry_pkg;

    typedef enum logic [1:0] {
        WAIT_A = 2'b00,
        WAIT_B = 2'b01,
        READY  = 2'b10
    } entry_state_t;

    localparam logic KEY_RELEASED = 1'b1;

endpackage

// File: rtl/operand_entry_key_debounce.sv
// Synchronizes one active-low pushbutton, debounces it and emits a single
// press pulse per accepted 1->0 level change.
module key_debounce
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic press_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             meta_r;
    logic             sync_r;
    logic             level_r;
    logic             level_d_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       fill_r;
    logic             armed_r;
    logic             pulse_r;

    // Two-flop synchronizer, idling at the released level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_r <= KEY_RELEASED;
            sync_r <= KEY_RELEASED;
        end else begin
            meta_r <= key_n;
            sync_r <= meta_r;
        end
    end

    // Accept a level change only after it has been stable long enough.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r     <= '0;
            level_r   <= KEY_RELEASED;
            level_d_r <= KEY_RELEASED;
        end else begin
            level_d_r <= level_r;
            if (sync_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r == CNT_LAST) begin
                cnt_r   <= '0;
                level_r <= sync_r;
            end else begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // The synchronizer resets to "released", so a key held through reset
    // would otherwise look like a fresh press. Pulses are only armed once a
    // genuine released level has travelled through the synchronizer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_r  <= 2'b00;
            armed_r <= 1'b0;
        end else begin
            fill_r  <= {fill_r[0], 1'b1};
            armed_r <= armed_r | (fill_r[1] & (sync_r == KEY_RELEASED));
        end
    end

    // Registered falling-edge detector on the debounced level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pulse_r <= 1'b0;
        end else begin
            pulse_r <= armed_r & level_d_r & ~level_r;
        end
    end

    assign press_pulse = pulse_r;

endmodule

// File: rtl/operand_entry.sv
// Captures operand A, operand B and carry-in from the switches on successive
// ENTER presses and holds them stable for the adder and display stages.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter_n,
    input  logic             clear_n,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             sw_cin,
    output logic [WIDTH:0]   a_out,
    output logic [WIDTH:0]   b_out,
    output logic             cin_out,
    output logic             operands_valid,
    output logic [1:0]       state_out
);

    logic             enter_pulse_s;
    logic             clear_pulse_s;
    logic [WIDTH-1:0] sw_meta_r;
    logic [WIDTH-1:0] sw_sync_r;
    logic             cin_meta_r;
    logic             cin_sync_r;

    entry_state_t     state_r;
    entry_state_t     state_nxt_s;
    logic [WIDTH:0]   a_r;
    logic [WIDTH:0]   a_nxt_s;
    logic [WIDTH:0]   b_r;
    logic [WIDTH:0]   b_nxt_s;
    logic             cin_r;
    logic             cin_nxt_s;
    logic             valid_r;
    logic             valid_nxt_s;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clk         (clk),
        .reset       (reset),
        .key_n       (enter_n),
        .press_pulse (enter_pulse_s)
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clk         (clk),
        .reset       (reset),
        .key_n       (clear_n),
        .press_pulse (clear_pulse_s)
    );

    // Two-flop synchronizers for the data and carry switches.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_meta_r  <= '0;
            sw_sync_r  <= '0;
            cin_meta_r <= 1'b0;
            cin_sync_r <= 1'b0;
        end else begin
            sw_meta_r  <= sw_data;
            sw_sync_r  <= sw_meta_r;
            cin_meta_r <= sw_cin;
            cin_sync_r <= cin_meta_r;
        end
    end

    // Sequencer next-state and operand updates; clear outranks enter.
    always_comb begin
        state_nxt_s = state_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        cin_nxt_s   = cin_r;
        valid_nxt_s = valid_r;
        if (clear_pulse_s) begin
            state_nxt_s = WAIT_A;
            a_nxt_s     = '0;
            b_nxt_s     = '0;
            cin_nxt_s   = 1'b0;
            valid_nxt_s = 1'b0;
        end else if (enter_pulse_s) begin
            case (state_r)
                WAIT_A: begin
                    a_nxt_s     = {1'b0, sw_sync_r};
                    state_nxt_s = WAIT_B;
                end
                WAIT_B: begin
                    b_nxt_s     = {1'b0, sw_sync_r};
                    cin_nxt_s   = cin_sync_r;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = READY;
                end
                READY: begin
                    a_nxt_s     = {1'b0, sw_sync_r};
                    valid_nxt_s = 1'b0;
                    state_nxt_s = WAIT_B;
                end
                default: begin
                    state_nxt_s = WAIT_A;
                end
            endcase
        end else begin
            case (state_r)
                WAIT_A, WAIT_B, READY: state_nxt_s = state_r;
                default:               state_nxt_s = WAIT_A;
            endcase
        end
    end

    // State and operand registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= WAIT_A;
            a_r     <= '0;
            b_r     <= '0;
            cin_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
            cin_r   <= cin_nxt_s;
            valid_r <= valid_nxt_s;
        end
    end

    assign a_out          = a_r;
    assign b_out          = b_r;
    assign cin_out        = cin_r;
    assign operands_valid = valid_r;
    assign state_out      = state_r;

endmodule

// File: tb/tb_operand_entry.sv
// Directed bench for operand_entry with a short debounce window.
module tb_operand_entry;

    localparam int WIDTH = 4;
    localparam int DB    = 4;
    localparam int LAT   = 8;

    logic             clk;
    logic             reset;
    logic             enter_n;
    logic             clear_n;
    logic [WIDTH-1:0] sw_data;
    logic             sw_cin;
    logic [WIDTH:0]   a_out;
    logic [WIDTH:0]   b_out;
    logic             cin_out;
    logic             operands_valid;
    logic [1:0]       state_out;

    int vectors;
    int miscompares;
    int n;

    operand_entry #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DB)) dut (
        .clk            (clk),
        .reset          (reset),
        .enter_n        (enter_n),
        .clear_n        (clear_n),
        .sw_data        (sw_data),
        .sw_cin         (sw_cin),
        .a_out          (a_out),
        .b_out          (b_out),
        .cin_out        (cin_out),
        .operands_valid (operands_valid),
        .state_out      (state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors = vectors + 1;
        if (got !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) @(negedge clk);
    endtask

    // Returns the number of cycles until any output changes, 0 if none within limit.
    task automatic wait_change(input int limit, output int cycles);
        logic [13:0] snap;
        bit          seen;
        snap   = {a_out, b_out, cin_out, operands_valid, state_out};
        seen   = 1'b0;
        cycles = 0;
        for (int i = 1; i <= limit && !seen; i++) begin
            @(negedge clk);
            if ({a_out, b_out, cin_out, operands_valid, state_out} != snap) begin
                seen   = 1'b1;
                cycles = i;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset   = 1'b1;
        enter_n = 1'b1;
        clear_n = 1'b1;
        sw_data = 4'h0;
        sw_cin  = 1'b0;
        ticks(3);
        check_eq("rst_a",     32'(a_out),          32'h0);
        check_eq("rst_b",     32'(b_out),          32'h0);
        check_eq("rst_cin",   32'(cin_out),        32'h0);
        check_eq("rst_valid", 32'(operands_valid), 32'h0);
        check_eq("rst_state", 32'(state_out),      32'h0);
        reset = 1'b0;
        ticks(6);

        // Operand A
        sw_data = 4'hA;
        enter_n = 1'b0;
        wait_change(40, n);
        check_eq("a_lat",   32'(n),         32'(LAT));
        check_eq("a_val",   32'(a_out),     32'h0A);
        check_eq("a_state", 32'(state_out), 32'h1);
        ticks(2);
        enter_n = 1'b1;
        ticks(10);

        // Operand B and carry
        sw_data = 4'h7;
        sw_cin  = 1'b1;
        enter_n = 1'b0;
        wait_change(40, n);
        check_eq("b_lat",   32'(n),              32'(LAT));
        check_eq("b_val",   32'(b_out),          32'h07);
        check_eq("b_cin",   32'(cin_out),        32'h1);
        check_eq("b_valid", 32'(operands_valid), 32'h1);
        check_eq("b_state", 32'(state_out),      32'h2);
        check_eq("b_a_hold",32'(a_out),          32'h0A);
        ticks(2);
        enter_n = 1'b1;
        ticks(10);

        // Re-entry from READY
        sw_data = 4'h3;
        enter_n = 1'b0;
        wait_change(40, n);
        check_eq("re_lat",   32'(n),              32'(LAT));
        check_eq("re_a",     32'(a_out),          32'h03);
        check_eq("re_b",     32'(b_out),          32'h07);
        check_eq("re_cin",   32'(cin_out),        32'h1);
        check_eq("re_valid", 32'(operands_valid), 32'h0);
        check_eq("re_state", 32'(state_out),      32'h1);
        ticks(2);
        enter_n = 1'b1;
        ticks(10);

        // Bounce: short glitch must not capture, held key captures once
        sw_data = 4'h5;
        sw_cin  = 1'b0;
        enter_n = 1'b0;
        ticks(3);
        enter_n = 1'b1;
        ticks(2);
        enter_n = 1'b0;
        wait_change(40, n);
        check_eq("bn_lat",   32'(n),              32'(LAT));
        check_eq("bn_b",     32'(b_out),          32'h05);
        check_eq("bn_cin",   32'(cin_out),        32'h0);
        check_eq("bn_valid", 32'(operands_valid), 32'h1);
        check_eq("bn_state", 32'(state_out),      32'h2);
        wait_change(20, n);
        check_eq("bn_hold", 32'(n), 32'h0);
        enter_n = 1'b1;
        ticks(10);

        // Clear beats enter on the same cycle
        sw_data = 4'hE;
        enter_n = 1'b0;
        clear_n = 1'b0;
        wait_change(40, n);
        check_eq("clr_lat",   32'(n),              32'(LAT));
        check_eq("clr_a",     32'(a_out),          32'h0);
        check_eq("clr_b",     32'(b_out),          32'h0);
        check_eq("clr_cin",   32'(cin_out),        32'h0);
        check_eq("clr_valid", 32'(operands_valid), 32'h0);
        check_eq("clr_state", 32'(state_out),      32'h0);
        ticks(2);
        enter_n = 1'b1;
        clear_n = 1'b1;
        ticks(10);

        // Reset mid-debounce with the key still held afterwards
        sw_data = 4'h6;
        enter_n = 1'b0;
        ticks(2);
        reset = 1'b1;
        ticks(2);
        reset = 1'b0;
        wait_change(30, n);
        check_eq("mr_nochg", 32'(n),         32'h0);
        check_eq("mr_state", 32'(state_out), 32'h0);
        check_eq("mr_a",     32'(a_out),     32'h0);
        enter_n = 1'b1;
        ticks(10);

        // Capture works again after a proper release
        sw_data = 4'h9;
        enter_n = 1'b0;
        wait_change(40, n);
        check_eq("post_lat",   32'(n),         32'(LAT));
        check_eq("post_a",     32'(a_out),     32'h09);
        check_eq("post_state", 32'(state_out), 32'h1);
        enter_n = 1'b1;
        ticks(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_entry.md
Name: operand_entry

Overview:
Upstream operand-capture stage for the variable-width adder on the DE1_SoC board. Synchronizes the data switches and debounces two active-low pushbuttons. A three-state sequencer then latches operand A, operand B and carry-in on successive ENTER presses. It presents zero-extended WIDTH+1-bit operands with a valid flag to the adder and hex-display stages, so operands stay stable while switches move.

Parameters:
WIDTH, 4, operand data width; outputs are WIDTH+1 bits wide.
DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required before a key level change is accepted (1 ms at 50 MHz); benches override to 4.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
enter_n  input  1  ENTER pushbutton (KEY0), active-low, asynchronous to clk.
clear_n  input  1  CLEAR pushbutton (KEY1), active-low, asynchronous to clk.
sw_data  input  WIDTH  operand value from switches, asynchronous.
sw_cin  input  1  carry-in switch, asynchronous.
a_out  output  WIDTH+1  latched operand A, MSB forced 0.
b_out  output  WIDTH+1  latched operand B, MSB forced 0.
cin_out  output  1  latched carry-in.
operands_valid  output  1  high while A, B and cin form a complete captured set.
state_out  output  2  current sequencer state encoding, used as a display hint.

Behaviour:
- Reset (async assert, released synchronously by design use):
  - a_out, b_out, cin_out, operands_valid = 0; state_out = WAIT_A (2'b00).
  - Key synchronizer flops and debounced key levels = 1 (released); switch synchronizer flops = 0.
  - Debounce counters = 0.
- Synchronization: two-flop synchronizer on every input bit. A switch change is visible internally 2 cycles later.
- Debounce, per key:
  - Counter increments each cycle the synchronized level differs from the debounced level.
  - Counter clears on any cycle they agree.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter clears.
  - A 1-cycle press pulse fires in the cycle after the debounced level goes 1->0.
  - Release produces no pulse. A held key produces exactly one pulse.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse.
- Sequencer states: WAIT_A=00, WAIT_B=01, READY=10; 11 unreachable and recovers to WAIT_A.
  - WAIT_A + enter pulse: a_out <= {0, sw_sync}; go to WAIT_B.
  - WAIT_B + enter pulse: b_out <= {0, sw_sync}; cin_out <= cin_sync; operands_valid <= 1; go to READY.
  - READY + enter pulse: a_out <= new value; b_out and cin_out hold; operands_valid <= 0; go to WAIT_B.
  - Any state + clear pulse: a_out, b_out, cin_out, operands_valid <= 0; go to WAIT_A.
- Simultaneous enter and clear pulses: clear wins.
- All outputs are registered and update on the clk edge at which the pulse is high.
- Latency:
  - Key press edge to output update = 2 (sync) + DEBOUNCE_CYCLES + 1 (pulse) + 1 cycles.
  - Switch changes without a key press never alter outputs.
- Reset mid-debounce or mid-sequence: all progress is discarded and no pulse fires after release.
- Values captured are the synchronized switch values in the pulse cycle.

Decomposition:
- Package operand_entry_pkg:
  - entry_state_t enum (WAIT_A, WAIT_B, READY) as 2-bit logic.
  - Constant KEY_RELEASED = 1'b1.
- Sub-module key_debounce, instantiated twice.
  - Parameter DEBOUNCE_CYCLES.
  - Ports clk, reset, key_n, press_pulse.
  - Contains its own synchronizer, counter sized $clog2(DEBOUNCE_CYCLES+1), and edge detector.
- Top holds switch synchronizers, state register and operand registers.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4):
- Reset: hold reset 3 cycles with keys released -> all outputs 0, state_out=00, operands_valid=0.
- Full entry:
  - Stimulus: sw_data=4'hA, press enter 10 cycles, release; then sw_data=4'h7, sw_cin=1, press enter.
  - Required: after first press a_out=5'h0A, state=01.
  - Required: after second press b_out=5'h07, cin_out=1, operands_valid=1, state=10.
  - Required: output update exactly 8 cycles after each enter_n fall.
- Bounce rejection:
  - Stimulus: enter_n low 3 cycles, high 2, low 3, then held low 20 cycles.
  - Required: exactly one capture, at the end of the first 4-cycle stable low run.
  - Required: no second pulse while held.
- Re-entry from READY: press enter with sw_data=4'h3 -> a_out=5'h03, b_out unchanged, operands_valid=0, state=01.
- Clear priority: enter and clear pressed on the same cycle in READY -> all operands 0, operands_valid=0, state=00.
- Reset mid-debounce: assert reset 2 cycles into an enter press, release reset with key still low -> no capture, state=00.
